vending_machine: RTL and testbench
==================================

# vending_machine

Coin-operated vending controller that accepts 5- and 10-rupee coins, accumulates credit against the price of a selected item and dispenses one product. It also signals when 5 rupees of change are due. It is a leaf block between the coin/selection front end (level inputs sampled per clock) and the dispense/return actuators (one-cycle pulse outputs). All state is registered on a single clock.

## Interface
- No parameters; the price table is fixed (see Operation).
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- item_no  input  4  item selection code.
- five_rup  input  1  5-rupee coin present this cycle.
- ten_rup  input  1  10-rupee coin present this cycle.
- product  output  1  dispense pulse, one cycle per vend.
- change  output  1  return-5-rupees pulse, coincident with product.

## Operation
- Price table:
  - item_no 4'b0001 = 15
  - 4'b0010 = 20
  - 4'b0011 = 25
  - 4'b0100 = 30
  - All other codes are invalid.
- Coin sampling:
  - Each rising edge with five_rup=1 deposits 5.
  - Each rising edge with ten_rup=1 deposits 10.
  - If both are high in the same cycle, 15 is deposited.
  - A held input counts once per cycle.
- Credit register holds 0..25 in steps of 5, encoded as FSM states S0, S5, S10, S15, S20, S25.
- Item latching:
  - On the first accepted coin of a transaction (credit S0), item_no is latched together with that coin.
  - item_no changes while credit is nonzero are ignored until the transaction ends.
- Invalid item: at credit S0, if item_no is invalid, coins are rejected. Credit stays S0 and no output is asserted.
- Per edge, new = credit + deposit, compared with the price of the latched item (or of item_no when at S0):
  - new < price: credit <= new; product=0, change=0.
  - new == price: credit <= S0; product=1, change=0.
  - new == price+5: credit <= S0; product=1, change=1.
  - new == price+10: reachable only with a double coin. credit <= S0; product=1, change=1; the excess 5 is discarded.
- No deposit: credit holds; outputs 0.
- Reset (rst=0 at an edge):
  - credit <= S0, latched item cleared, product=0, change=0.
  - Coins sampled in that cycle are discarded; reset has priority over everything.

## Timing
- Outputs are registered.
- product/change go high in the cycle following the edge that sampled the completing coin. They stay high for exactly one cycle, then return to 0 unless the next edge also completes a vend.
- Vend latency: 1 clock after the final coin edge.
- Back-to-back transactions allowed.
  - A coin sampled on the edge right after a vend edge starts a new transaction from S0 and re-latches item_no.
- Reset values: product=0, change=0, credit S0.
- Reset mid-transaction forfeits accumulated credit. No refund pulse is generated.
- Outputs never assert without a coin deposit on the preceding edge.

## Test plan
- Reset: rst=0 for 1 cycle after arbitrary coins -> product=0, change=0. Then item 0001 with 5 inserted twice -> no vend (credit only 10 after reset).
- Item 0001, five_rup high 3 consecutive cycles -> product=1, change=0 for one cycle after the 3rd edge; idle afterwards.
- Item 0001, ten_rup high 2 cycles -> product=1, change=1 after the 2nd edge. Item 0010, sequence 5,10,5 -> product=1, change=0 after the 3rd coin.
- Item 0100, ten_rup held 3 cycles -> vend after the 3rd edge. Holding it a 4th cycle -> new transaction at credit 10, no output.
- Item 0010, 10 inserted, then rst=0 one cycle, then 10 -> no vend; next 10 -> product=1, change=0.
- Item 0000 with coins -> no output, credit S0. Item 0001 with one 5, then switch to item 0100 and insert 5,5 -> vend at 15 (latched item). Both coins high with item 0001 -> immediate vend, change=0.

Source files
------------

// File: rtl/vending_machine_if.sv
// Coin/selection front end to vending controller bundle.
// master drives item_no and coin strobes and observes the vend pulses;
// slave is the controller side.
interface vending_machine_if;
  logic [3:0] item_no;
  logic       five_rup;
  logic       ten_rup;
  logic       product;
  logic       change;

  modport master (
    output item_no,
    output five_rup,
    output ten_rup,
    input  product,
    input  change
  );

  modport slave (
    input  item_no,
    input  five_rup,
    input  ten_rup,
    output product,
    output change
  );
endinterface

// File: rtl/vending_machine.sv
// Coin vending controller: accumulates 5/10 coins against a fixed price table.
// Latency: product/change pulse one clock after the completing coin edge.
// No backpressure: coins are level strobes sampled every clock, never stalled.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-low reset
//   bus  - slave side of vending_machine_if (item_no, five_rup, ten_rup in;
//          product, change out as registered one-cycle pulses)
module vending_machine (
  input  logic               clk,
  input  logic               rst,
  vending_machine_if.slave   bus
);

  typedef enum logic [2:0] {
    S0  = 3'd0,
    S5  = 3'd1,
    S10 = 3'd2,
    S15 = 3'd3,
    S20 = 3'd4,
    S25 = 3'd5
  } state_t;

  state_t     state;
  logic [3:0] item_q;
  logic       product_q;
  logic       change_q;

  logic [5:0] credit;
  logic [5:0] deposit;
  logic [5:0] new_credit;
  logic [5:0] price;
  logic [3:0] active_item;

  // Price of an item code; 0 marks an invalid code.
  function automatic logic [5:0] price_of(input logic [3:0] code);
    case (code)
      4'b0001: price_of = 6'd15;
      4'b0010: price_of = 6'd20;
      4'b0011: price_of = 6'd25;
      4'b0100: price_of = 6'd30;
      default: price_of = 6'd0;
    endcase
  endfunction

  // Only values below the highest price (30) are ever stored as credit.
  function automatic state_t state_of(input logic [5:0] value);
    case (value)
      6'd5:    state_of = S5;
      6'd10:   state_of = S10;
      6'd15:   state_of = S15;
      6'd20:   state_of = S20;
      6'd25:   state_of = S25;
      default: state_of = S0;
    endcase
  endfunction

  always_comb begin
    credit = 6'd0;
    case (state)
      S5:      credit = 6'd5;
      S10:     credit = 6'd10;
      S15:     credit = 6'd15;
      S20:     credit = 6'd20;
      S25:     credit = 6'd25;
      default: credit = 6'd0;
    endcase

    deposit = 6'd0;
    if (bus.five_rup) deposit = deposit + 6'd5;
    if (bus.ten_rup)  deposit = deposit + 6'd10;

    // A fresh transaction prices against the live selection; an open one
    // stays bound to the item latched with its first coin.
    active_item = (state == S0) ? bus.item_no : item_q;
    price       = price_of(active_item);
    new_credit  = credit + deposit;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S0;
      item_q    <= 4'd0;
      product_q <= 1'b0;
      change_q  <= 1'b0;
    end else begin
      product_q <= 1'b0;
      change_q  <= 1'b0;
      // Coins offered at S0 against an invalid code are simply not taken.
      if (deposit != 6'd0 && price != 6'd0) begin
        if (state == S0) item_q <= bus.item_no;
        if (new_credit < price) begin
          state <= state_of(new_credit);
        end else begin
          // Overpay is at most price+10 (double coin); one 5 is returned
          // and any further excess is kept.
          state     <= S0;
          product_q <= 1'b1;
          change_q  <= (new_credit != price);
        end
      end
    end
  end

  assign bus.product = product_q;
  assign bus.change  = change_q;

endmodule

// File: tb/tb_vending_machine.sv
module tb_vending_machine;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  vending_machine_if bus ();

  vending_machine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {product, change} per sampled edge.
  logic [1:0] exp_q[$];

  // Reference model state for the random phase.
  int m_credit;
  int m_item;

  task automatic check_val(input string tag, input logic [1:0] got, input logic [1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got product/change=%b required=%b", tag, got, exp);
    end
  endtask

  function automatic int model_price(input int code);
    case (code)
      1: return 15;
      2: return 20;
      3: return 25;
      4: return 30;
      default: return 0;
    endcase
  endfunction

  // Drive one cycle, queue its expectation, then compare after the edge.
  task automatic step(input string tag, input logic [3:0] item, input logic five,
                      input logic ten, input logic rst_v, input logic [1:0] exp);
    logic [1:0] e;
    @(negedge clk);
    bus.item_no  = item;
    bus.five_rup = five;
    bus.ten_rup  = ten;
    rst          = rst_v;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check_val(tag, {bus.product, bus.change}, e);
    end
  endtask

  // Model: returns expected outputs for this edge and advances state.
  function automatic logic [1:0] model_step(input int item, input logic five,
                                           input logic ten, input logic rst_v);
    int dep, pr, n;
    if (!rst_v) begin
      m_credit = 0;
      m_item   = 0;
      return 2'b00;
    end
    dep = (five ? 5 : 0) + (ten ? 10 : 0);
    if (dep == 0) return 2'b00;
    if (m_credit == 0) begin
      pr = model_price(item);
      if (pr == 0) return 2'b00;
      m_item = item;
    end else begin
      pr = model_price(m_item);
    end
    n = m_credit + dep;
    if (n < pr) begin
      m_credit = n;
      return 2'b00;
    end
    m_credit = 0;
    return {1'b1, (n > pr)};
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst          = 1'b0;
    bus.item_no  = 4'd0;
    bus.five_rup = 1'b0;
    bus.ten_rup  = 1'b0;

    // Reset with coins present; then only 10 credited after reset.
    step("rst_coins",   4'd1, 1, 1, 0, 2'b00);
    step("rst_idle",    4'd1, 0, 0, 0, 2'b00);
    step("post_rst_5a", 4'd1, 1, 0, 1, 2'b00);
    step("post_rst_5b", 4'd1, 1, 0, 1, 2'b00);
    step("post_rst_5c", 4'd1, 1, 0, 1, 2'b10);
    step("idle_a",      4'd1, 0, 0, 1, 2'b00);

    // Item 1, three fives.
    step("i1_5x3_a", 4'd1, 1, 0, 1, 2'b00);
    step("i1_5x3_b", 4'd1, 1, 0, 1, 2'b00);
    step("i1_5x3_c", 4'd1, 1, 0, 1, 2'b10);
    step("i1_idle",  4'd1, 0, 0, 1, 2'b00);
    step("i1_idle2", 4'd1, 0, 0, 1, 2'b00);

    // Item 1, two tens -> change.
    step("i1_10x2_a", 4'd1, 0, 1, 1, 2'b00);
    step("i1_10x2_b", 4'd1, 0, 1, 1, 2'b11);

    // Item 2, 5,10,5.
    step("i2_5",   4'd2, 1, 0, 1, 2'b00);
    step("i2_10",  4'd2, 0, 1, 1, 2'b00);
    step("i2_5b",  4'd2, 1, 0, 1, 2'b10);

    // Item 4, ten held four cycles; fourth starts a new transaction.
    step("i4_10a", 4'd4, 0, 1, 1, 2'b00);
    step("i4_10b", 4'd4, 0, 1, 1, 2'b00);
    step("i4_10c", 4'd4, 0, 1, 1, 2'b10);
    step("i4_10d", 4'd4, 0, 1, 1, 2'b00);
    step("i4_10e", 4'd4, 0, 1, 1, 2'b00);
    step("i4_10f", 4'd4, 0, 1, 1, 2'b10);

    // Item 2, reset mid-transaction forfeits credit.
    step("i2_pre",   4'd2, 0, 1, 1, 2'b00);
    step("i2_rst",   4'd2, 0, 1, 0, 2'b00);
    step("i2_post1", 4'd2, 0, 1, 1, 2'b00);
    step("i2_post2", 4'd2, 0, 1, 1, 2'b10);

    // Invalid item rejects coins.
    step("inv_10",  4'd0, 0, 1, 1, 2'b00);
    step("inv_5",   4'd0, 1, 0, 1, 2'b00);
    step("inv_9",   4'd9, 1, 1, 1, 2'b00);

    // Latched item survives a selection change.
    step("latch_5a", 4'd1, 1, 0, 1, 2'b00);
    step("latch_5b", 4'd4, 1, 0, 1, 2'b00);
    step("latch_5c", 4'd4, 1, 0, 1, 2'b10);

    // Double coins, including consecutive-edge vends.
    step("dbl_i1",   4'd1, 1, 1, 1, 2'b10);
    step("dbl_i1b",  4'd1, 1, 1, 1, 2'b10);
    step("dbl_p5a",  4'd1, 1, 0, 1, 2'b00);
    step("dbl_p5b",  4'd1, 1, 1, 1, 2'b11);
    step("dbl_p10a", 4'd1, 0, 1, 1, 2'b00);
    step("dbl_p10b", 4'd1, 1, 1, 1, 2'b11);
    step("dbl_i4a",  4'd4, 1, 1, 1, 2'b00);
    step("dbl_i4b",  4'd4, 1, 1, 1, 2'b10);

    // Item 3 overpaid by 5.
    step("i3_a", 4'd3, 0, 1, 1, 2'b00);
    step("i3_b", 4'd3, 0, 1, 1, 2'b00);
    step("i3_c", 4'd3, 0, 1, 1, 2'b11);

    // Random traffic against the reference model, starting from reset.
    step("rand_rst", 4'd0, 0, 0, 0, 2'b00);
    m_credit = 0;
    m_item   = 0;
    for (int i = 0; i < 400; i++) begin
      logic [3:0] it;
      logic       f, t, r;
      it = 4'($urandom_range(0, 5));
      f  = 1'($urandom_range(0, 1));
      t  = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 29) != 0);
      step("rand", it, f, t, r, model_step(int'(it), f, t, r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
